// File: rtl/txser_lanes.sv
// rtl/txser_lanes.sv - multi-lane parallel-to-serial TX serializer with PRBS7/clock/zero modes
module txser_lanes #(
    parameter int LANES   = 4,
    parameter int RATIO   = 8,
    parameter int UFLOW_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic [LANES*RATIO-1:0]   din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [LANES-1:0]         dout,
    output logic                     word_start,
    output logic [UFLOW_W-1:0]       underflow_cnt
);

    localparam int CW = $clog2(RATIO);
    localparam int W  = LANES * RATIO;

    localparam logic [1:0] M_DATA  = 2'b00;
    localparam logic [1:0] M_PRBS  = 2'b01;
    localparam logic [1:0] M_CLOCK = 2'b10;
    localparam logic [1:0] M_ZERO  = 2'b11;

    localparam logic [RATIO-1:0] CLK_LANE = {(RATIO/2){2'b01}};
    localparam logic [W-1:0]     CLK_ALL  = {LANES{CLK_LANE}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           cnt;
    logic [W-1:0]            shreg;
    logic [W-1:0]            buf_data;
    logic                    buf_valid;
    logic [1:0]              cur_mode;
    logic [LANES-1:0][6:0]   lfsr;
    logic [LANES-1:0][6:0]   lfsr_adv;
    logic [W-1:0]            prbs_word;
    logic [6:0]              prbs_s;
    logic                    prbs_b;
    logic                    boundary;
    logic                    accept;

    assign boundary = (state == IDLE) || (cnt == CW'(RATIO - 1));
    assign accept   = din_valid && !buf_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only a boundary can change state; DATA with nothing buffered parks in IDLE
    always_comb begin
        state_next = state;
        if (boundary) begin
            if (mode == M_DATA && !buf_valid) begin
                state_next = IDLE;
            end else begin
                state_next = RUN;
            end
        end
    end

    // Outputs: serial bit is the low bit of each lane's shift register while running
    always_comb begin
        dout       = '0;
        word_start = (state == RUN) && (cnt == '0);
        din_ready  = !buf_valid;
        if (state == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                dout[l] = shreg[l*RATIO];
            end
        end
    end

    // Next PRBS7 word per lane: RATIO Fibonacci steps, bit i of the word is the i-th generated bit
    always_comb begin
        prbs_word = '0;
        lfsr_adv  = lfsr;
        prbs_s    = '0;
        prbs_b    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            prbs_s = lfsr[l];
            for (int i = 0; i < RATIO; i++) begin
                prbs_b              = prbs_s[6] ^ prbs_s[5];
                prbs_word[l*RATIO+i] = prbs_b;
                prbs_s              = {prbs_s[5:0], prbs_b};
            end
            lfsr_adv[l] = prbs_s;
        end
    end

    // Datapath: skid buffer, word load / shift, LFSR advance and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            shreg         <= '0;
            buf_data      <= '0;
            buf_valid     <= 1'b0;
            cur_mode      <= M_DATA;
            underflow_cnt <= '0;
            for (int l = 0; l < LANES; l++) begin
                lfsr[l] <= 7'h7F ^ 7'(l);
            end
        end else begin
            if (accept) begin
                buf_data  <= din;
                buf_valid <= 1'b1;
            end
            if (boundary) begin
                cur_mode <= mode;
                case (mode)
                    M_DATA: begin
                        if (buf_valid) begin
                            shreg     <= buf_data;
                            buf_valid <= 1'b0;
                            cnt       <= '0;
                        end else if (state == RUN && cur_mode == M_DATA &&
                                     underflow_cnt != '1) begin
                            underflow_cnt <= underflow_cnt + 1'b1;
                        end
                    end
                    M_PRBS: begin
                        shreg <= prbs_word;
                        lfsr  <= lfsr_adv;
                        cnt   <= '0;
                    end
                    M_CLOCK: begin
                        shreg <= CLK_ALL;
                        cnt   <= '0;
                    end
                    default: begin
                        shreg <= '0;
                        cnt   <= '0;
                    end
                endcase
            end else begin
                cnt <= cnt + 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    shreg[l*RATIO +: RATIO] <= shreg[l*RATIO +: RATIO] >> 1;
                end
            end
        end
    end

endmodule
